// File: rtl/seg_scan_ctrl_if.sv
// Value-source / display-side bundle for the 4-digit scan controller.
// The value source is the master; the scan controller is the slave.
interface seg_scan_ctrl_if;
  logic        load;
  logic [15:0] digits;
  logic [3:0]  dp_in;
  logic        blank_lz;
  logic        pending;
  logic        load_ack;
  logic [1:0]  digit_sel;
  logic [3:0]  anode;
  logic [3:0]  nibble;
  logic        dp_n;
  logic        frame_tick;

  modport master (
    output load, digits, dp_in, blank_lz,
    input  pending, load_ack, digit_sel,
    input  anode, nibble, dp_n, frame_tick
  );

  modport slave (
    input  load, digits, dp_in, blank_lz,
    output pending, load_ack, digit_sel,
    output anode, nibble, dp_n, frame_tick
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// 4-digit common-anode 7-seg scan scheduler with dead-time blanking,
// frame-synchronous double buffering and leading-zero suppression.
module seg_scan_ctrl #(
  parameter int ON_CYCLES   = 12500,
  parameter int DEAD_CYCLES = 250,
  parameter int CNT_W       = 15
) (
  input  logic          clk,
  input  logic          rst,
  seg_scan_ctrl_if.slave bus
);

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } state_t;

  localparam int DL = (DEAD_CYCLES > 0) ? DEAD_CYCLES - 1 : 0;
  localparam logic [CNT_W-1:0] ON_LAST   = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DL);
  localparam bit NO_DEAD = (DEAD_CYCLES == 0);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       sel_q, sel_d;
  logic [3:0]       anode_q, anode_d;
  logic [3:0]       nib_q, nib_d;
  logic             dpn_q, dpn_d;
  logic             tick_q, tick_d;
  logic             ack_q, ack_d;
  logic             pend_q, pend_d;
  logic [15:0]      pbuf_q, pbuf_d;
  logic [3:0]       pdp_q, pdp_d;
  logic [15:0]      act_q, act_d;
  logic [3:0]       adp_q, adp_d;
  logic             sup_q, sup_d;
  logic             show_end;
  logic             blank_end;
  logic             commit;

  function automatic logic lz_sup(
    input logic [15:0] v,
    input logic [1:0]  k,
    input logic        en
  );
    logic z3, z32, z321;
    z3   = (v[15:12] == 4'd0);
    z32  = z3 && (v[11:8] == 4'd0);
    z321 = z32 && (v[7:4] == 4'd0);
    unique case (k)
      2'd3:    return en && z3;
      2'd2:    return en && z32;
      2'd1:    return en && z321;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] an_of(
    input logic [1:0] k,
    input logic       sup
  );
    return sup ? 4'b1111 : ~(4'b0001 << k);
  endfunction

  assign show_end  = (state_q == SHOW) && (cnt_q == ON_LAST);
  assign blank_end = (state_q == BLANK) && (cnt_q == DEAD_LAST);
  assign commit    = show_end && (sel_q == 2'd3) && pend_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    sel_d   = sel_q;
    anode_d = anode_q;
    nib_d   = nib_q;
    dpn_d   = dpn_q;
    tick_d  = 1'b0;
    ack_d   = 1'b0;
    pend_d  = pend_q;
    pbuf_d  = pbuf_q;
    pdp_d   = pdp_q;
    act_d   = act_q;
    adp_d   = adp_q;
    sup_d   = sup_q;

    // Commit reads the old buffer, so a same-cycle load stays pending.
    if (commit) begin
      act_d  = pbuf_q;
      adp_d  = pdp_q;
      ack_d  = 1'b1;
      pend_d = 1'b0;
    end
    if (bus.load) begin
      pbuf_d = bus.digits;
      pdp_d  = bus.dp_in;
      pend_d = 1'b1;
    end

    unique case (state_q)
      BLANK: begin
        if (blank_end) begin
          state_d = SHOW;
          cnt_d   = '0;
          anode_d = an_of(sel_q, sup_q);
        end
      end
      SHOW: begin
        if (show_end) begin
          sel_d  = sel_q + 2'd1;
          cnt_d  = '0;
          tick_d = (sel_q == 2'd3);
          nib_d  = act_d[{sel_d, 2'b00} +: 4];
          sup_d  = lz_sup(act_d, sel_d, bus.blank_lz);
          dpn_d  = sup_d | ~adp_d[sel_d];
          if (NO_DEAD) begin
            state_d = SHOW;
            anode_d = an_of(sel_d, sup_d);
          end else begin
            state_d = BLANK;
            anode_d = 4'b1111;
          end
        end
      end
      default: begin
        state_d = BLANK;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BLANK;
      cnt_q   <= '0;
      sel_q   <= 2'd0;
      anode_q <= 4'b1111;
      nib_q   <= 4'd0;
      dpn_q   <= 1'b1;
      tick_q  <= 1'b0;
      ack_q   <= 1'b0;
      pend_q  <= 1'b0;
      pbuf_q  <= 16'd0;
      pdp_q   <= 4'd0;
      act_q   <= 16'd0;
      adp_q   <= 4'd0;
      sup_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      anode_q <= anode_d;
      nib_q   <= nib_d;
      dpn_q   <= dpn_d;
      tick_q  <= tick_d;
      ack_q   <= ack_d;
      pend_q  <= pend_d;
      pbuf_q  <= pbuf_d;
      pdp_q   <= pdp_d;
      act_q   <= act_d;
      adp_q   <= adp_d;
      sup_q   <= sup_d;
    end
  end

  assign bus.pending    = pend_q;
  assign bus.load_ack   = ack_q;
  assign bus.digit_sel  = sel_q;
  assign bus.anode      = anode_q;
  assign bus.nibble     = nib_q;
  assign bus.dp_n       = dpn_q;
  assign bus.frame_tick = tick_q;

endmodule
